platform_interrupt_arbiter: RTL and testbench

Platform-level interrupt arbiter feeding the csr_controller's pad_external_interrupt input. Gathers NUM_SOURCES device interrupt lines, gates each per source, and arbitrates by programmable priority against a threshold. Exposes a claim/complete register window so the machine-mode trap handler can identify and retire the winning source. Sits beside csr_controller and commits state on the same phase-2 edge as the CSR file.

---
 rtl/platform_interrupt_arbiter_if.sv | 12 +
 rtl/platform_interrupt_arbiter.sv | 162 ++++++++++++++++
 tb/tb_platform_interrupt_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/platform_interrupt_arbiter_if.sv
// Register-window bus between the trap-handler side and the platform interrupt arbiter.
// The requester drives the strobes, address and write data; the arbiter returns read data.
interface platform_interrupt_arbiter_if;
  logic        cfg_read;
  logic        cfg_write;
  logic [7:0]  cfg_address;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;

  modport master (output cfg_read, cfg_write, cfg_address, cfg_wdata, input cfg_rdata);
  modport slave  (input cfg_read, cfg_write, cfg_address, cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/platform_interrupt_arbiter.sv
// Platform interrupt arbiter: per-source gateways, priority/threshold arbitration, claim/complete window.
// Optional macro PLATFORM_IRQ_EDGE_COUNT_EN keeps a 2-bit replay count of edges seen while busy.
module platform_interrupt_arbiter #(
  parameter int unsigned NUM_SOURCES   = 8,
  parameter int unsigned PRIORITY_BITS = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2:1]                 phase,
  input  logic [NUM_SOURCES-1:0]     irq_sources,
  platform_interrupt_arbiter_if.slave cfg,
  output logic                       pad_external_interrupt
);
  localparam int unsigned ID_BITS        = 5;
  localparam logic [7:0]  ADDR_PENDING   = 8'h20;
  localparam logic [7:0]  ADDR_ENABLE    = 8'h21;
  localparam logic [7:0]  ADDR_THRESHOLD = 8'h22;
  localparam logic [7:0]  ADDR_CLAIM     = 8'h23;
  localparam logic [7:0]  ADDR_EDGE_SEL  = 8'h24;

  typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, IN_SERVICE = 2'd2} gw_state_e;

  gw_state_e                state_q [NUM_SOURCES];
  gw_state_e                state_d [NUM_SOURCES];
  logic [PRIORITY_BITS-1:0] prio_q  [NUM_SOURCES];
  logic [PRIORITY_BITS-1:0] prio_d  [NUM_SOURCES];
  logic [NUM_SOURCES-1:0]   enable_q, enable_d, edge_sel_q, edge_sel_d, prev_irq_q;
  logic [PRIORITY_BITS-1:0] threshold_q, threshold_d;
`ifdef PLATFORM_IRQ_EDGE_COUNT_EN
  logic [1:0]               cnt_q [NUM_SOURCES];
  logic [1:0]               cnt_d [NUM_SOURCES];
`endif

  logic                     commit;
  logic [NUM_SOURCES-1:0]   pending, eligible, rise;
  logic [PRIORITY_BITS-1:0] best_prio;
  logic [ID_BITS-1:0]       winner_id, complete_id;
  logic                     claim, complete;
  logic                     unused_wdata;

  assign commit       = (phase == 2'b10);
  assign rise         = irq_sources & ~prev_irq_q;
  assign claim        = cfg.cfg_read && !cfg.cfg_write && (cfg.cfg_address == ADDR_CLAIM)
                        && (winner_id != '0);
  assign complete     = cfg.cfg_write && (cfg.cfg_address == ADDR_CLAIM);
  assign complete_id  = cfg.cfg_wdata[ID_BITS-1:0];
  assign unused_wdata = ^cfg.cfg_wdata;

  // Eligibility and winner: strict '>' keeps the lowest ID on priority ties.
  always_comb begin
    pending   = '0;
    eligible  = '0;
    best_prio = '0;
    winner_id = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      pending[i]  = (state_q[i] == PENDING);
      eligible[i] = pending[i] && enable_q[i] && (prio_q[i] > threshold_q);
      if (eligible[i] && (prio_q[i] > best_prio)) begin
        best_prio = prio_q[i];
        winner_id = ID_BITS'(i + 1);
      end
    end
  end

  assign pad_external_interrupt = |eligible;

  always_comb begin
    cfg.cfg_rdata = '0;
    if (cfg.cfg_read && !cfg.cfg_write) begin
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
        if (cfg.cfg_address == 8'(i)) cfg.cfg_rdata = 32'(prio_q[i]);
      end
      case (cfg.cfg_address)
        ADDR_PENDING:   cfg.cfg_rdata = 32'(pending);
        ADDR_ENABLE:    cfg.cfg_rdata = 32'(enable_q);
        ADDR_THRESHOLD: cfg.cfg_rdata = 32'(threshold_q);
        ADDR_CLAIM:     cfg.cfg_rdata = 32'(winner_id);
        ADDR_EDGE_SEL:  cfg.cfg_rdata = 32'(edge_sel_q);
        default:        ;
      endcase
    end
  end

  // Next state: register writes and gateway transitions, all from pre-edge values.
  always_comb begin
    logic trig;
    logic done;
    trig        = 1'b0;
    done        = 1'b0;
    state_d     = state_q;
    prio_d      = prio_q;
    enable_d    = enable_q;
    threshold_d = threshold_q;
    edge_sel_d  = edge_sel_q;
`ifdef PLATFORM_IRQ_EDGE_COUNT_EN
    cnt_d       = cnt_q;
`endif
    if (cfg.cfg_write) begin
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
        if (cfg.cfg_address == 8'(i)) prio_d[i] = cfg.cfg_wdata[PRIORITY_BITS-1:0];
      end
      case (cfg.cfg_address)
        ADDR_ENABLE:    enable_d    = cfg.cfg_wdata[NUM_SOURCES-1:0];
        ADDR_THRESHOLD: threshold_d = cfg.cfg_wdata[PRIORITY_BITS-1:0];
        ADDR_EDGE_SEL:  edge_sel_d  = cfg.cfg_wdata[NUM_SOURCES-1:0];
        default:        ;
      endcase
    end
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      trig = edge_sel_q[i] ? rise[i] : irq_sources[i];
      done = complete && (complete_id == ID_BITS'(i + 1));
      case (state_q[i])
        IDLE:       if (trig) state_d[i] = PENDING;
        PENDING:    if (claim && (winner_id == ID_BITS'(i + 1))) state_d[i] = IN_SERVICE;
        IN_SERVICE: begin
          if (done) begin
`ifdef PLATFORM_IRQ_EDGE_COUNT_EN
            state_d[i] = (cnt_q[i] != 2'd0) ? PENDING : IDLE;
`else
            state_d[i] = IDLE;
`endif
          end
        end
        default:    state_d[i] = IDLE;
      endcase
`ifdef PLATFORM_IRQ_EDGE_COUNT_EN
      // Edges arriving while busy are banked and replayed one per complete.
      if (edge_sel_q[i] && rise[i] && (state_q[i] != IDLE) && (cnt_q[i] != 2'd3))
        cnt_d[i] = cnt_q[i] + 2'd1;
      if ((state_q[i] == IN_SERVICE) && done && (cnt_q[i] != 2'd0))
        cnt_d[i] = cnt_d[i] - 2'd1;
`endif
    end
  end

  // Reset acts on any edge; everything else only on the commit edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
        state_q[i] <= IDLE;
        prio_q[i]  <= '0;
`ifdef PLATFORM_IRQ_EDGE_COUNT_EN
        cnt_q[i]   <= '0;
`endif
      end
      enable_q    <= '0;
      threshold_q <= '0;
      edge_sel_q  <= '0;
      prev_irq_q  <= '0;
    end else if (commit) begin
      state_q     <= state_d;
      prio_q      <= prio_d;
`ifdef PLATFORM_IRQ_EDGE_COUNT_EN
      cnt_q       <= cnt_d;
`endif
      enable_q    <= enable_d;
      threshold_q <= threshold_d;
      edge_sel_q  <= edge_sel_d;
      prev_irq_q  <= irq_sources;
    end
  end
endmodule

// File: tb/tb_platform_interrupt_arbiter.sv
// Directed vector bench for platform_interrupt_arbiter; each vector spans one non-commit and one commit edge.
module tb_platform_interrupt_arbiter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:1] phase = 2'b01;
  logic [7:0] irq   = '0;
  logic       pad;

  platform_interrupt_arbiter_if cfg_bus ();

  platform_interrupt_arbiter #(.NUM_SOURCES(8), .PRIORITY_BITS(3)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .phase                  (phase),
    .irq_sources            (irq),
    .cfg                    (cfg_bus.slave),
    .pad_external_interrupt (pad)
  );

  always #5 clock = ~clock;

`ifdef PLATFORM_IRQ_EDGE_COUNT_EN
  localparam bit EC = 1'b1;
`else
  localparam bit EC = 1'b0;
`endif

  typedef struct {
    bit          rst;
    bit          rd;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  irq;
    logic [31:0] exp_rdata;
    bit          exp_pad;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(bit rst, bit rd, bit wr, logic [7:0] a, logic [31:0] d,
                              logic [7:0] i, logic [31:0] e, bit p);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d;
    v.irq = i; v.exp_rdata = e; v.exp_pad = p;
    vecs.push_back(v);
  endfunction

  function automatic void t_rd(logic [7:0] a, logic [7:0] i, logic [31:0] e, bit p);
    add(1'b0, 1'b1, 1'b0, a, 32'h0, i, e, p);
  endfunction

  function automatic void t_wr(logic [7:0] a, logic [31:0] d, logic [7:0] i, bit p);
    add(1'b0, 1'b0, 1'b1, a, d, i, 32'h0, p);
  endfunction

  function automatic void t_nop(logic [7:0] i, bit p);
    add(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, i, 32'h0, p);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec%0d: got %h want %h", name, idx, got, want);
    end
  endtask

  // Inputs held across a non-commit edge, checked, then committed.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clock);
    phase                 = 2'b01;
    reset                 = v.rst;
    irq                   = v.irq;
    cfg_bus.cfg_read      = v.rd;
    cfg_bus.cfg_write     = v.wr;
    cfg_bus.cfg_address   = v.addr;
    cfg_bus.cfg_wdata     = v.wdata;
    @(negedge clock);
    reset = 1'b0;
    phase = 2'b10;
    #1;
    check("rdata", idx, cfg_bus.cfg_rdata, v.exp_rdata);
    check("pad", idx, 32'(pad), 32'(v.exp_pad));
    @(posedge clock);
  endtask

  initial begin
    logic [7:0] map_addr [14];
    map_addr = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h30};

    // Reset state: every register reads zero.
    foreach (map_addr[k]) t_rd(map_addr[k], 8'h00, 32'h0, 1'b0);

    // Two level sources at equal priority: lowest ID wins, then the other, then none.
    t_wr(8'h02, 32'd5, 8'h00, 1'b0);
    t_wr(8'h05, 32'd5, 8'h00, 1'b0);
    t_wr(8'h21, 32'h24, 8'h00, 1'b0);
    t_wr(8'h22, 32'd0, 8'h00, 1'b0);
    t_rd(8'h02, 8'h00, 32'd5, 1'b0);
    t_rd(8'h21, 8'h00, 32'h24, 1'b0);
    t_nop(8'h24, 1'b0);
    t_rd(8'h20, 8'h24, 32'h24, 1'b1);
    t_rd(8'h23, 8'h24, 32'd3, 1'b1);
    t_rd(8'h23, 8'h24, 32'd6, 1'b1);
    t_rd(8'h23, 8'h24, 32'd0, 1'b0);
    t_rd(8'h20, 8'h24, 32'h0, 1'b0);
    t_wr(8'h23, 32'd3, 8'h00, 1'b0);
    t_wr(8'h23, 32'd6, 8'h00, 1'b0);

    // Threshold boundary: priority equal to threshold never interrupts.
    t_wr(8'h00, 32'd2, 8'h00, 1'b0);
    t_wr(8'h22, 32'd2, 8'h00, 1'b0);
    t_wr(8'h21, 32'h01, 8'h00, 1'b0);
    t_rd(8'h20, 8'h01, 32'h0, 1'b0);
    t_rd(8'h20, 8'h01, 32'h1, 1'b0);
    t_wr(8'h22, 32'd1, 8'h01, 1'b0);
    t_rd(8'h22, 8'h01, 32'd1, 1'b1);
    // Higher priority source 1 beats source 0.
    t_wr(8'h01, 32'd6, 8'h03, 1'b1);
    t_wr(8'h21, 32'h03, 8'h03, 1'b1);
    t_rd(8'h23, 8'h03, 32'd2, 1'b1);
    t_rd(8'h23, 8'h03, 32'd1, 1'b1);
    t_wr(8'h23, 32'd1, 8'h03, 1'b0);

    // Held level source: wrong-ID complete ignored, right-ID complete re-pends.
    t_wr(8'h23, 32'd7, 8'h02, 1'b0);
    t_rd(8'h20, 8'h02, 32'h0, 1'b0);
    t_wr(8'h23, 32'd2, 8'h02, 1'b0);
    t_rd(8'h20, 8'h02, 32'h0, 1'b0);
    t_rd(8'h20, 8'h02, 32'h2, 1'b1);
    // Read and write together: no read data, no claim.
    add(1'b0, 1'b1, 1'b1, 8'h23, 32'd0, 8'h02, 32'h0, 1'b1);
    t_rd(8'h20, 8'h02, 32'h2, 1'b1);
    t_rd(8'h23, 8'h00, 32'd2, 1'b1);
    t_wr(8'h23, 32'd2, 8'h00, 1'b0);

    // Edge source 3: one trigger, claim, two more edges while in service.
    t_wr(8'h03, 32'd4, 8'h00, 1'b0);
    t_wr(8'h21, 32'h08, 8'h00, 1'b0);
    t_wr(8'h24, 32'h08, 8'h00, 1'b0);
    t_rd(8'h24, 8'h00, 32'h08, 1'b0);
    t_nop(8'h08, 1'b0);
    t_rd(8'h23, 8'h08, 32'd4, 1'b1);
    t_nop(8'h00, 1'b0);
    t_nop(8'h08, 1'b0);
    t_nop(8'h00, 1'b0);
    t_nop(8'h08, 1'b0);
    t_nop(8'h00, 1'b0);
    t_wr(8'h23, 32'd4, 8'h00, 1'b0);
    t_rd(8'h20, 8'h00, EC ? 32'h08 : 32'h0, EC);
    t_rd(8'h23, 8'h00, EC ? 32'd4 : 32'd0, EC);
    t_wr(8'h23, 32'd4, 8'h00, 1'b0);
    t_rd(8'h20, 8'h00, EC ? 32'h08 : 32'h0, EC);
    t_rd(8'h23, 8'h00, EC ? 32'd4 : 32'd0, EC);
    t_wr(8'h23, 32'd4, 8'h00, 1'b0);
    t_rd(8'h20, 8'h00, 32'h0, 1'b0);

    // Reset while source 4 is in service and source 2 keeps pad high.
    t_wr(8'h04, 32'd6, 8'h00, 1'b0);
    t_wr(8'h21, 32'h14, 8'h00, 1'b0);
    t_nop(8'h14, 1'b0);
    t_rd(8'h23, 8'h14, 32'd5, 1'b1);
    t_rd(8'h20, 8'h14, 32'h04, 1'b1);
    add(1'b1, 1'b1, 1'b0, 8'h23, 32'd0, 8'h00, 32'h0, 1'b0);
    t_wr(8'h23, 32'd5, 8'h00, 1'b0);
    t_rd(8'h20, 8'h00, 32'h0, 1'b0);
    t_rd(8'h21, 8'h00, 32'h0, 1'b0);
    t_rd(8'h04, 8'h00, 32'h0, 1'b0);
    t_rd(8'h22, 8'h00, 32'h0, 1'b0);

    cfg_bus.cfg_read    = 1'b0;
    cfg_bus.cfg_write   = 1'b0;
    cfg_bus.cfg_address = '0;
    cfg_bus.cfg_wdata   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("pad_after_reset", -1, 32'(pad), 32'h0);

    foreach (vecs[k]) apply(vecs[k], k);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
